// File: rtl/fir_ctrl.sv
// Sequencing controller for a 4-tap FIR: forwards the sample stream, tracks samples
// in flight, and swaps double-buffered coefficients only after the filter has drained.
module fir_ctrl #(
  parameter int MAX_OUT       = 8,
  parameter int DRAIN_TIMEOUT = 64
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        CFG_WE,
  input  logic [1:0]  CFG_ADDR,
  input  logic [15:0] CFG_DATA,
  input  logic        CFG_COMMIT,
  input  logic        S_VALID,
  input  logic [15:0] S_DATA,
  output logic        S_READY,
  output logic [15:0] DIN,
  output logic        VIN,
  output logic [15:0] H0,
  output logic [15:0] H1,
  output logic [15:0] H2,
  output logic [15:0] H3,
  input  logic        FIR_VOUT,
  output logic        BUSY,
  output logic        ERR,
  output logic [1:0]  DBG_STATE,
  output logic [3:0]  DBG_OUT_CNT
);

  // Source handshake: a sample transfers on a cycle where S_VALID && S_READY.
  // S_READY is derived from registered state only and never looks at S_VALID.

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_SWAP  = 2'd2
  } state_t;

  localparam logic [3:0] MAX_OUT_C  = 4'(MAX_OUT);
  localparam logic [7:0] DRAIN_LAST = 8'(DRAIN_TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [3:0]  out_cnt_q, out_cnt_d;
  logic [7:0]  drain_cnt_q, drain_cnt_d;
  logic        pend_q, pend_d;
  logic        err_q, err_d;
  logic        vin_q, vin_d;
  logic [15:0] din_q, din_d;
  logic [15:0] shadow_q [4];
  logic [15:0] shadow_d [4];
  logic [15:0] h_q [4];
  logic [15:0] h_d [4];

  logic s_ready;
  logic busy;
  logic accept;
  logic drain_empty;
  logic drain_expired;

  assign accept        = S_VALID && s_ready;
  assign drain_empty   = (out_cnt_q == 4'd0);
  assign drain_expired = (drain_cnt_q == DRAIN_LAST);

  // State register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= ST_RUN;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:   if (pend_q || CFG_COMMIT) state_d = ST_DRAIN;
      ST_DRAIN: if (drain_empty || drain_expired) state_d = ST_SWAP;
      ST_SWAP:  state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
  end

  // Output logic
  always_comb begin
    s_ready = (state_q == ST_RUN) && (out_cnt_q < MAX_OUT_C);
    busy    = (state_q != ST_RUN);
  end

  always_comb begin
    out_cnt_d = out_cnt_q;
    if (state_q == ST_SWAP)                           out_cnt_d = 4'd0;
    else if (accept && !FIR_VOUT)                     out_cnt_d = out_cnt_q + 4'd1;
    else if (!accept && FIR_VOUT && out_cnt_q != 4'd0) out_cnt_d = out_cnt_q - 4'd1;

    drain_cnt_d = (state_q == ST_DRAIN) ? drain_cnt_q + 8'd1 : 8'd0;

    // A commit arriving in the last DRAIN cycle is folded into this swap: its
    // shadow writes are already visible to the SWAP copy.
    pend_d = pend_q || CFG_COMMIT;
    if (state_q == ST_DRAIN && state_d == ST_SWAP) pend_d = 1'b0;

    err_d = err_q || (state_q == ST_DRAIN && !drain_empty && drain_expired);

    vin_d = accept;
    din_d = accept ? S_DATA : din_q;

    for (int i = 0; i < 4; i++) begin
      shadow_d[i] = shadow_q[i];
      h_d[i]      = (state_q == ST_SWAP) ? shadow_q[i] : h_q[i];
    end
    if (CFG_WE) shadow_d[CFG_ADDR] = CFG_DATA;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      out_cnt_q   <= 4'd0;
      drain_cnt_q <= 8'd0;
      pend_q      <= 1'b0;
      err_q       <= 1'b0;
      vin_q       <= 1'b0;
      din_q       <= 16'd0;
      for (int i = 0; i < 4; i++) begin
        shadow_q[i] <= 16'd0;
        h_q[i]      <= 16'd0;
      end
    end else begin
      out_cnt_q   <= out_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      pend_q      <= pend_d;
      err_q       <= err_d;
      vin_q       <= vin_d;
      din_q       <= din_d;
      for (int i = 0; i < 4; i++) begin
        shadow_q[i] <= shadow_d[i];
        h_q[i]      <= h_d[i];
      end
    end
  end

  assign S_READY     = s_ready;
  assign BUSY        = busy;
  assign ERR         = err_q;
  assign DIN         = din_q;
  assign VIN         = vin_q;
  assign H0          = h_q[0];
  assign H1          = h_q[1];
  assign H2          = h_q[2];
  assign H3          = h_q[3];
  assign DBG_STATE   = state_q;
  assign DBG_OUT_CNT = out_cnt_q;

endmodule

// File: tb/tb_fir_ctrl.sv
// Directed bench for fir_ctrl: streaming, backpressure, coefficient swap, drain
// timeout, commit/write collisions and reset during DRAIN.
module tb_fir_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_we;
  logic [1:0]  cfg_addr;
  logic [15:0] cfg_data;
  logic        cfg_commit;
  logic        s_valid;
  logic [15:0] s_data;
  logic        s_ready;
  logic [15:0] din;
  logic        vin;
  logic [15:0] h0, h1, h2, h3;
  logic        fir_vout;
  logic        busy;
  logic        err;
  logic [1:0]  dbg_state;
  logic [3:0]  dbg_out_cnt;

  logic        echo_en;
  logic        vout_drv;

  int n_checks = 0;
  int n_errors = 0;
  logic [15:0] exp_q[$];

  localparam logic [1:0] RUN = 2'd0, DRAIN = 2'd1, SWAP = 2'd2;

  assign fir_vout = echo_en ? vin : vout_drv;

  fir_ctrl #(.MAX_OUT(8), .DRAIN_TIMEOUT(64)) dut (
    .CLK(clk), .RST(rst),
    .CFG_WE(cfg_we), .CFG_ADDR(cfg_addr), .CFG_DATA(cfg_data), .CFG_COMMIT(cfg_commit),
    .S_VALID(s_valid), .S_DATA(s_data), .S_READY(s_ready),
    .DIN(din), .VIN(vin),
    .H0(h0), .H1(h1), .H2(h2), .H3(h3),
    .FIR_VOUT(fir_vout), .BUSY(busy), .ERR(err),
    .DBG_STATE(dbg_state), .DBG_OUT_CNT(dbg_out_cnt)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic check_h(input string tag, input logic [15:0] e0, input logic [15:0] e1,
                         input logic [15:0] e2, input logic [15:0] e3);
    check({tag, "_h0"}, 32'(h0), 32'(e0));
    check({tag, "_h1"}, 32'(h1), 32'(e1));
    check({tag, "_h2"}, 32'(h2), 32'(e2));
    check({tag, "_h3"}, 32'(h3), 32'(e3));
  endtask

  task automatic send_samples(input int n, input logic [15:0] base);
    for (int i = 0; i < n; i++) begin
      s_valid = 1'b1;
      s_data  = base + 16'(i);
      tick();
    end
    s_valid = 1'b0;
  endtask

  task automatic write_shadow(input logic [1:0] a, input logic [15:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic commit();
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
  endtask

  initial begin
    int accepts;
    int drain_cycles;
    logic [15:0] exp_d;

    rst = 1'b1; cfg_we = 1'b0; cfg_addr = 2'd0; cfg_data = 16'd0; cfg_commit = 1'b0;
    s_valid = 1'b0; s_data = 16'd0; echo_en = 1'b0; vout_drv = 1'b0;

    // Reset and simple stream with FIR_VOUT echoing VIN
    repeat (3) tick();
    check("rst_din", 32'(din), 32'd0);
    check("rst_vin", 32'(vin), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check_h("rst", 16'd0, 16'd0, 16'd0, 16'd0);
    rst = 1'b0;
    tick();
    check("post_rst_ready", 32'(s_ready), 32'd1);
    check("post_rst_cnt", 32'(dbg_out_cnt), 32'd0);

    echo_en = 1'b1;
    accepts = 0;
    for (int i = 1; i <= 4; i++) begin
      exp_q.push_back(16'(i));
      s_valid = 1'b1;
      s_data  = 16'(i);
      tick();
      if (vin) begin
        accepts++;
        exp_d = exp_q.pop_front();
        check("stream_din", 32'(din), 32'(exp_d));
      end
    end
    s_valid = 1'b0;
    check("stream_vin_count", 32'(accepts), 32'd4);
    check("stream_q_empty", 32'(exp_q.size()), 32'd0);
    tick();
    check("stream_vin_low", 32'(vin), 32'd0);
    check("stream_din_hold", 32'(din), 32'd4);
    tick();
    check("stream_cnt_zero", 32'(dbg_out_cnt), 32'd0);
    echo_en = 1'b0;

    // Backpressure at MAX_OUT=8
    accepts = 0;
    s_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      s_data = 16'h0100 + 16'(i);
      tick();
      if (vin) accepts++;
    end
    check("bp_accepts", 32'(accepts), 32'd8);
    check("bp_ready_low", 32'(s_ready), 32'd0);
    check("bp_cnt8", 32'(dbg_out_cnt), 32'd8);
    vout_drv = 1'b1;
    tick();
    vout_drv = 1'b0;
    check("bp_reopen", 32'(s_ready), 32'd1);
    tick();
    check("bp_one_accept", 32'(vin), 32'd1);
    tick();
    check("bp_closed_again", 32'(vin), 32'd0);
    check("bp_ready_low2", 32'(s_ready), 32'd0);
    vout_drv = 1'b1;
    tick();
    check("bp_cnt7", 32'(dbg_out_cnt), 32'd7);
    tick();
    check("bp_simul_vin", 32'(vin), 32'd1);
    check("bp_simul_cnt", 32'(dbg_out_cnt), 32'd7);
    s_valid = 1'b0;
    repeat (7) tick();
    vout_drv = 1'b0;
    check("bp_drained", 32'(dbg_out_cnt), 32'd0);

    // Coefficient swap with 3 samples outstanding
    for (int i = 0; i < 4; i++) write_shadow(2'(i), 16'(i + 1));
    check_h("shadow_only", 16'd0, 16'd0, 16'd0, 16'd0);
    send_samples(3, 16'h0200);
    check("swap_cnt3", 32'(dbg_out_cnt), 32'd3);
    commit();
    s_valid = 1'b1;
    s_data  = 16'hDEAD;
    check("swap_busy", 32'(busy), 32'd1);
    check("swap_ready_low", 32'(s_ready), 32'd0);
    check("swap_state_drain", 32'(dbg_state), 32'(DRAIN));
    for (int p = 0; p < 3; p++) begin
      vout_drv = 1'b1;
      tick();
      vout_drv = 1'b0;
      check("swap_pulse_busy", 32'(busy), 32'd1);
      check("swap_pulse_novin", 32'(vin), 32'd0);
      if (p < 2) begin
        tick();
        check("swap_gap_busy", 32'(busy), 32'd1);
        check("swap_gap_ready", 32'(s_ready), 32'd0);
        check("swap_gap_novin", 32'(vin), 32'd0);
      end
    end
    check("swap_cnt0", 32'(dbg_out_cnt), 32'd0);
    check("swap_h_old", 32'(h0), 32'd0);
    tick();
    check("swap_state_swap", 32'(dbg_state), 32'(SWAP));
    check("swap_h_still_old", 32'(h3), 32'd0);
    check("swap_novin", 32'(vin), 32'd0);
    tick();
    s_valid = 1'b0;
    check("swap_back_run", 32'(dbg_state), 32'(RUN));
    check("swap_not_busy", 32'(busy), 32'd0);
    check("swap_ready", 32'(s_ready), 32'd1);
    check_h("swap_new", 16'd1, 16'd2, 16'd3, 16'd4);
    check("swap_err_clear", 32'(err), 32'd0);

    // Drain timeout with 2 samples never returned
    send_samples(2, 16'h0300);
    commit();
    drain_cycles = 0;
    while (dbg_state == DRAIN && drain_cycles < 200) begin
      drain_cycles++;
      tick();
    end
    check("to_drain_cycles", 32'(drain_cycles), 32'd64);
    check("to_state_swap", 32'(dbg_state), 32'(SWAP));
    check("to_err_set", 32'(err), 32'd1);
    tick();
    check("to_cnt_forced", 32'(dbg_out_cnt), 32'd0);
    check("to_run", 32'(dbg_state), 32'(RUN));
    check("to_ready", 32'(s_ready), 32'd1);
    send_samples(1, 16'h0400);
    check("to_resume_vin", 32'(vin), 32'd1);
    check("to_resume_din", 32'(din), 32'h0400);
    tick();
    check("to_err_sticky", 32'(err), 32'd1);
    vout_drv = 1'b1;
    tick();
    vout_drv = 1'b0;
    check("to_cleanup_cnt", 32'(dbg_out_cnt), 32'd0);

    // Commit during DRAIN plus a shadow write in the SWAP cycle
    send_samples(1, 16'h0500);
    commit();
    check("col_drain", 32'(dbg_state), 32'(DRAIN));
    commit();
    check("col_still_drain", 32'(dbg_state), 32'(DRAIN));
    vout_drv = 1'b1;
    tick();
    vout_drv = 1'b0;
    tick();
    check("col_swap", 32'(dbg_state), 32'(SWAP));
    write_shadow(2'd2, 16'hBEEF);
    check("col_run", 32'(dbg_state), 32'(RUN));
    check_h("col_old", 16'd1, 16'd2, 16'd3, 16'd4);
    repeat (3) tick();
    check("col_one_swap", 32'(dbg_state), 32'(RUN));
    check("col_one_swap_busy", 32'(busy), 32'd0);
    commit();
    tick();
    tick();
    check("col_second_run", 32'(dbg_state), 32'(RUN));
    check_h("col_second", 16'd1, 16'd2, 16'hBEEF, 16'd4);

    // Reset asserted while in DRAIN with a pending commit
    send_samples(1, 16'h0600);
    commit();
    commit();
    check("mid_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check("mid_state", 32'(dbg_state), 32'(RUN));
    check("mid_busy_clr", 32'(busy), 32'd0);
    check("mid_err", 32'(err), 32'd0);
    check("mid_cnt", 32'(dbg_out_cnt), 32'd0);
    check("mid_vin", 32'(vin), 32'd0);
    check("mid_din", 32'(din), 32'd0);
    check_h("mid", 16'd0, 16'd0, 16'd0, 16'd0);
    tick();
    tick();
    rst = 1'b0;
    repeat (3) tick();
    check("mid_pend_lost", 32'(dbg_state), 32'(RUN));
    check("mid_ready", 32'(s_ready), 32'd1);
    check_h("mid_after", 16'd0, 16'd0, 16'd0, 16'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
